// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell is reused for every bit,
// LSB first. A start/busy/done handshake sequences it and yields diff = a - b plus borrow.
module serial_subtractor_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             bin_q, bin_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;

    logic d_bit;
    logic bout;
    logic last_bit;

    // Shared 1-bit subtract cell working on the current operand LSBs.
    assign d_bit    = a_q[0] ^ b_q[0] ^ bin_q;
    assign bout     = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bin_q);
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        bin_d    = bin_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    bin_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // After WIDTH shifts the first processed bit sits at bit 0.
                res_d = {d_bit, res_q[WIDTH-1:1]};
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                bin_d = bout;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    state_d  = DONE;
                    diff_d   = {d_bit, res_q[WIDTH-1:1]};
                    borrow_d = bout;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            bin_q    <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            bin_q    <= bin_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    assign busy       = (state_q == RUN);
    assign done       = (state_q == DONE);
    assign diff       = diff_q;
    assign borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed and random self-checking bench for serial_subtractor_ctrl (WIDTH=8).
module tb_serial_subtractor_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow_out;

    int checks;
    int failures;
    logic [7:0] prev_d;
    logic       prev_bo;

    serial_subtractor_ctrl #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One start pulse, then wait (bounded) for done and check timing and result.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v,
                          input logic [7:0] exp_d, input logic exp_bo, input string tag);
        int n;
        int busy_cnt;
        logic stable;
        a = ta;
        b = tb_v;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        busy_cnt = 0;
        stable = 1'b1;
        while (!done && n < 20) begin
            if (busy) busy_cnt++;
            if (diff !== prev_d || borrow_out !== prev_bo) stable = 1'b0;
            tick();
            n++;
        end
        check({tag, "_latency"}, n, 9);
        check({tag, "_busy_cycles"}, busy_cnt, 8);
        check({tag, "_held"}, {31'd0, stable}, 1);
        check({tag, "_busy_in_done"}, {31'd0, busy}, 0);
        check({tag, "_diff"}, {24'd0, diff}, {24'd0, exp_d});
        check({tag, "_borrow"}, {31'd0, borrow_out}, {31'd0, exp_bo});
        tick();
        check({tag, "_done_one_cycle"}, {31'd0, done}, 0);
        prev_d = exp_d;
        prev_bo = exp_bo;
    endtask

    initial begin
        int done_cnt;
        int t1;
        int t2;
        int t3;
        logic [7:0] ra;
        logic [7:0] rb;
        logic [7:0] md;
        logic       mb;

        checks = 0;
        failures = 0;
        prev_d = 8'h00;
        prev_bo = 1'b0;
        rst_n = 1'b0;
        start = 1'b0;
        a = 8'h00;
        b = 8'h00;
        #2;
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_diff", {24'd0, diff}, 0);
        check("rst_borrow", {31'd0, borrow_out}, 0);
        #10;
        rst_n = 1'b1;
        tick();

        // Basic, underflow and boundary vectors.
        run_op(8'h5A, 8'h3C, 8'h1E, 1'b0, "basic");
        run_op(8'h00, 8'h01, 8'hFF, 1'b1, "under1");
        run_op(8'h3C, 8'h5A, 8'hE2, 1'b1, "under2");
        run_op(8'h80, 8'h80, 8'h00, 1'b0, "equal");
        run_op(8'hFF, 8'h00, 8'hFF, 1'b0, "max_minus_0");
        run_op(8'h00, 8'hFF, 8'h01, 1'b1, "zero_minus_max");

        // Operand and start changes during RUN must be ignored.
        a = 8'hC8;
        b = 8'h19;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        a = 8'h01;
        b = 8'hFE;
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        t1 = 0;
        while (!done && t1 < 20) begin
            tick();
            t1++;
        end
        check("isolate_done_seen", {31'd0, done}, 1);
        check("isolate_diff", {24'd0, diff}, 32'hAF);
        check("isolate_borrow", {31'd0, borrow_out}, 0);
        tick();
        check("isolate_no_restart", {30'd0, busy, done}, 0);
        prev_d = 8'hAF;
        prev_bo = 1'b0;

        // start held high for 30 cycles: three results, ten cycles apart.
        a = 8'h10;
        b = 8'h20;
        start = 1'b1;
        done_cnt = 0;
        t1 = 0;
        t2 = 0;
        t3 = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) t1 = i;
                if (done_cnt == 2) t2 = i;
                if (done_cnt == 3) t3 = i;
            end
        end
        start = 1'b0;
        check("held_done_count", done_cnt, 3);
        check("held_gap1", t2 - t1, 10);
        check("held_gap2", t3 - t2, 10);
        check("held_diff", {24'd0, diff}, 32'hF0);
        check("held_borrow", {31'd0, borrow_out}, 1);
        tick();
        tick();
        prev_d = 8'hF0;
        prev_bo = 1'b1;

        // Reset in the middle of an operation.
        a = 8'h5A;
        b = 8'h3C;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 0);
        check("midrst_done", {31'd0, done}, 0);
        check("midrst_diff", {24'd0, diff}, 0);
        check("midrst_borrow", {31'd0, borrow_out}, 0);
        done_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done) done_cnt++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done || busy) done_cnt++;
        end
        check("midrst_no_done", done_cnt, 0);
        prev_d = 8'h00;
        prev_bo = 1'b0;
        run_op(8'h5A, 8'h3C, 8'h1E, 1'b0, "after_rst");

        // Random pairs against a reference model.
        for (int i = 0; i < 200; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            md = ra - rb;
            mb = (ra < rb);
            run_op(ra, rb, md, mb, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_subtractor_ctrl.md
Name: serial_subtractor_ctrl

Overview:
Bit-serial N-bit subtractor controller. It time-shares one 1-bit subtract cell (full-subtractor equation: half-subtractor plus borrow-in) across all operand bits, LSB first. A start/busy/done handshake sequences the cell. It computes diff = a - b and borrow_out over WIDTH bits, and is the multi-bit front end for the lab's subtractor datapath.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32).
CNT_W, $clog2(WIDTH)+1, bit-counter width (derived; do not override).

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request a subtraction; sampled only in IDLE.
a  input  WIDTH  minuend; captured when start is accepted.
b  input  WIDTH  subtrahend; captured when start is accepted.
busy  output  1  high while an operation is in RUN.
done  output  1  one-cycle pulse; result valid.
diff  output  WIDTH  a - b modulo 2^WIDTH; held until the next result.
borrow_out  output  1  final borrow (1 when a < b unsigned); held with diff.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values (async on rst_n=0):
  - state=IDLE, busy=0, done=0, diff=0, borrow_out=0.
  - Internal operand shift registers=0, borrow register=0, bit counter=0.
- Reset mid-operation: the operation is abandoned immediately. No done pulse is produced and outputs go to their reset values.
- FSM states: IDLE, RUN, DONE.
  - IDLE: if start=1 at an edge, capture a and b into shift registers, clear borrow and counter, go to RUN. Otherwise stay in IDLE.
  - RUN: busy=1. On each edge, process the current LSBs a0, b0 with borrow-in bin:
    - d = a0^b0^bin
    - bout = (~a0&b0) | (~(a0^b0)&bin)
    - Shift d into the result shift register MSB-ward (d lands in bit position = counter), shift both operands right, set bin <= bout, counter++.
    - On the edge that processes bit WIDTH-1, go to DONE.
  - DONE: done=1 and busy=0 for exactly one cycle. Next edge goes to IDLE.
- Output register update:
  - diff and borrow_out load from the result shift register and final borrow on the same edge that enters DONE, so they are stable whenever done=1.
  - diff and borrow_out hold their previous values throughout RUN and IDLE.
- Latency:
  - Start sampled at edge E0. Bits are processed at E1..E_WIDTH. done is high in the cycle after E_WIDTH. Latency = WIDTH+1 cycles from the start edge to done.
- Throughput: with start held high continuously, one operation per WIDTH+2 cycles. start is ignored in RUN and DONE; it is re-sampled only once the FSM is back in IDLE.
- Operand isolation: changes on a or b after capture have no effect on the current operation.
- Arithmetic:
  - Result is unsigned modulo 2^WIDTH. borrow_out=1 if and only if a < b unsigned.
  - Equal operands give diff=0, borrow_out=0.
- No illegal-state lockup: an unencoded state returns to IDLE on the next edge.

Test Plan:
- 1. Reset then basic subtract: WIDTH=8, a=0x5A, b=0x3C, one-cycle start -> busy high for 8 cycles, done pulses 9 cycles after the start edge, diff=0x1E, borrow_out=0.
- 2. Underflow: a=0x00, b=0x01 -> diff=0xFF, borrow_out=1. Also a=0x3C, b=0x5A -> diff=0xE2, borrow_out=1.
- 3. Boundaries: a=0x80, b=0x80 -> diff=0x00, borrow_out=0. a=0xFF, b=0x00 -> diff=0xFF, borrow_out=0. a=0x00, b=0xFF -> diff=0x01, borrow_out=1.
- 4. Handshake robustness:
  - start re-pulsed and a/b changed mid-RUN -> ignored, result matches the originally captured operands.
  - start held high for 30 cycles -> exactly 3 done pulses, 10 cycles apart.
- 5. Reset mid-operation: assert rst_n=0 at bit 4 of a=0x5A, b=0x3C -> busy, done, diff and borrow_out go to 0 immediately with no done pulse. A new start after release gives a correct result.
- 6. Randomised check: 200 random a/b pairs compared against (a-b) mod 256 and (a<b). diff and borrow_out must be held stable between done pulses.
